scr_stack_ctrl: RTL and testbench
=================================

SCR_STACK_CTRL -- requirements
Module: scr_stack_ctrl

Interface
REQ-001 Parameter SP_RESET, default 8'h00, stack-pointer value loaded on reset.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 OP_VALID  input  1  request strobe from CPU control unit.
REQ-005 OP_CODE  input  3  operation, type scr_op_t.
REQ-006 OP_ADDR  input  8  direct address for LD/ST, new SP value for WSP.
REQ-007 OP_DATA  input  10  write data for PUSH/ST.
REQ-008 OP_READY  output  1  controller idle and accepting a request.
REQ-009 RESULT_VALID  output  1  one-cycle completion pulse.
REQ-010 RESULT  output  10  read data (POP/LD), {2'b00,SP} (RSP), else 0.
REQ-011 ERR  output  1  stack overflow/underflow, qualified by RESULT_VALID.
REQ-012 SP  output  8  current stack pointer.
REQ-013 SCR_ADDR  output  8  address to scratch RAM.
REQ-014 SCR_WE  output  1  write enable to scratch RAM.
REQ-015 SCR_DATA_OUT  output  10  write data to scratch RAM.
REQ-016 SCR_DATA_IN  input  10  scratch RAM read data, combinational from SCR_ADDR.

Function
REQ-017 Operations: PUSH, POP, LD, ST, WSP (write SP), RSP (read SP); other codes complete as no-ops with ERR=0.
REQ-018 FSM states IDLE, EXEC, DONE; IDLE->EXEC on OP_VALID&&OP_READY; EXEC->DONE always; DONE->IDLE always.
REQ-019 OP_READY=1 only in IDLE; request fields captured on acceptance; OP_VALID outside IDLE ignored.
REQ-020 SCR_WE=1 only in EXEC for PUSH/ST without error; SCR_ADDR/SCR_DATA_OUT stable throughout EXEC, 0 otherwise.
REQ-021 PUSH: SCR_ADDR=SP-1 (mod 256), SP<=SP-1 at end of EXEC.
REQ-022 POP: SCR_ADDR=SP, RESULT<=SCR_DATA_IN at end of EXEC, SP<=SP+1 (mod 256).
REQ-023 LD/ST: SCR_ADDR=OP_ADDR; SP and depth unchanged.
REQ-024 WSP: SP<=OP_ADDR, depth<=0; RSP: RESULT<={2'b00,SP}.
REQ-025 Internal 9-bit depth counter 0..256: PUSH +1, POP -1.
REQ-026 PUSH at depth 256: no write, SP/depth unchanged, ERR=1.
REQ-027 POP at depth 0: SP/depth unchanged, RESULT=0, ERR=1.
REQ-028 SP wraps 8'h00->8'hFF on PUSH and 8'hFF->8'h00 on POP without error.
REQ-029 RESULT_VALID=1 exactly in DONE; latency acceptance->RESULT_VALID = 2 cycles; throughput one op per 3 cycles.
REQ-030 RESULT and ERR hold last values until next DONE.

Reset
REQ-031 RST asserted: state IDLE, SP=SP_RESET, depth=0, RESULT=0, ERR=0, RESULT_VALID=0, SCR_WE=0, SCR_ADDR=0, SCR_DATA_OUT=0, OP_READY=1 after release.
REQ-032 RST mid-EXEC aborts the op asynchronously: SCR_WE drops immediately, no SP change, no RESULT_VALID.

Structure
REQ-033 Package scr_pkg holds scr_op_t (3-bit enum), state enum, SCR_DATA_W=10, SCR_ADDR_W=8, SCR_DEPTH=256.
REQ-034 Single module; no sub-module; integrates with existing 256x10 scratch RAM by direct port connection.

Verification
REQ-035 Reset, PUSH 10'h155, PUSH 10'h2AA -> writes at 8'hFF then 8'hFE, SP=8'hFE, ERR=0.
REQ-036 Then POP, POP -> RESULT 10'h2AA then 10'h155, SP=8'h00, RESULT_VALID 2 cycles after each acceptance.
REQ-037 POP at depth 0 -> ERR=1, RESULT=0, SP unchanged, SCR_WE never asserted.
REQ-038 256 PUSHes then PUSH 10'h3FF -> 257th gives ERR=1, no write, SP=8'h00.
REQ-039 ST addr 8'h40 data 10'h0AB, LD 8'h40 -> RESULT 10'h0AB; WSP 8'h80 then RSP -> RESULT 10'h080.
REQ-040 RST asserted during PUSH EXEC -> SCR_WE falls same cycle, SP=SP_RESET, no RESULT_VALID.

Source files
------------

// File: rtl/scr_pkg.sv
// Shared types and sizing for the scratch-RAM stack controller.
package scr_pkg;

  localparam int SCR_DATA_W  = 10;
  localparam int SCR_ADDR_W  = 8;
  localparam int SCR_DEPTH   = 256;
  localparam int SCR_DEPTH_W = 9;   // must hold 0..SCR_DEPTH inclusive

  // Request opcodes; codes 6 and 7 are legal but complete as no-ops.
  typedef enum logic [2:0] {
    OP_PUSH = 3'd0,
    OP_POP  = 3'd1,
    OP_LD   = 3'd2,
    OP_ST   = 3'd3,
    OP_WSP  = 3'd4,
    OP_RSP  = 3'd5
  } scr_op_t;

  // Controller sequencing: accept, drive the RAM for one cycle, report.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } scr_state_t;

endpackage

// File: rtl/scr_stack_ctrl_if.sv
// Request/result handshake between the CPU control unit and the stack controller.
interface scr_stack_ctrl_if;

  logic                                 op_valid;
  scr_pkg::scr_op_t                     op_code;
  logic [scr_pkg::SCR_ADDR_W-1:0]       op_addr;
  logic [scr_pkg::SCR_DATA_W-1:0]       op_data;
  logic                                 op_ready;
  logic                                 result_valid;
  logic [scr_pkg::SCR_DATA_W-1:0]       result;
  logic                                 err;

  // CPU side: issues requests, consumes results.
  modport master (
    output op_valid, op_code, op_addr, op_data,
    input  op_ready, result_valid, result, err
  );

  // Controller side.
  modport slave (
    input  op_valid, op_code, op_addr, op_data,
    output op_ready, result_valid, result, err
  );

endinterface

// File: rtl/scr_stack_ctrl.sv
// Stack / direct-access controller in front of a 256x10 scratch RAM.
// One request is accepted in IDLE, the RAM is driven for the single EXEC
// cycle, and the result is reported with a one-cycle pulse in DONE.
// The stack grows downward: PUSH pre-decrements SP, POP post-increments.
module scr_stack_ctrl
  import scr_pkg::*;
#(
  parameter logic [SCR_ADDR_W-1:0] SP_RESET = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst,
  scr_stack_ctrl_if.slave       op_if,
  output logic [SCR_ADDR_W-1:0] sp_o,
  output logic [SCR_ADDR_W-1:0] scr_addr_o,
  output logic                  scr_we_o,
  output logic [SCR_DATA_W-1:0] scr_data_out_o,
  input  logic [SCR_DATA_W-1:0] scr_data_in_i
);

  // Controller state and registered outputs
  scr_state_t              state_q;
  scr_op_t                 op_q;
  logic [SCR_ADDR_W-1:0]   op_addr_q;
  logic                    op_err_q;
  logic [SCR_ADDR_W-1:0]   sp_q;
  logic [SCR_DEPTH_W-1:0]  depth_q;
  logic [SCR_DATA_W-1:0]   result_q;
  logic                    err_q;
  logic                    result_valid_q;
  logic                    op_ready_q;
  logic [SCR_ADDR_W-1:0]   scr_addr_q;
  logic                    scr_we_q;
  logic [SCR_DATA_W-1:0]   scr_data_q;

  // Acceptance-time decode (RAM drive for the coming EXEC cycle)
  logic                    accept_s;
  logic                    full_s;
  logic                    empty_s;
  logic [SCR_ADDR_W-1:0]   scr_addr_d;
  logic                    scr_we_d;
  logic [SCR_DATA_W-1:0]   scr_data_d;
  logic                    op_err_d;

  // End-of-EXEC architectural updates
  logic [SCR_ADDR_W-1:0]   sp_d;
  logic [SCR_DEPTH_W-1:0]  depth_d;
  logic [SCR_DATA_W-1:0]   result_d;

  assign accept_s = (state_q == ST_IDLE) && op_if.op_valid && op_ready_q;
  assign full_s   = (depth_q == SCR_DEPTH_W'(SCR_DEPTH));
  assign empty_s  = (depth_q == 9'd0);

  // Decode the incoming request into the RAM controls held during EXEC;
  // overflow/underflow is decided here so EXEC never writes on an error.
  always_comb begin
    scr_addr_d = 8'h00;
    scr_we_d   = 1'b0;
    scr_data_d = 10'h000;
    op_err_d   = 1'b0;
    case (op_if.op_code)
      OP_PUSH: begin
        scr_addr_d = sp_q - 8'h01;
        scr_we_d   = !full_s;
        scr_data_d = op_if.op_data;
        op_err_d   = full_s;
      end
      OP_POP: begin
        scr_addr_d = sp_q;
        op_err_d   = empty_s;
      end
      OP_LD: begin
        scr_addr_d = op_if.op_addr;
      end
      OP_ST: begin
        scr_addr_d = op_if.op_addr;
        scr_we_d   = 1'b1;
        scr_data_d = op_if.op_data;
      end
      default: begin
        scr_addr_d = 8'h00;
      end
    endcase
  end

  // Compute SP, depth and result committed at the end of EXEC from the
  // captured request; a faulted PUSH/POP leaves SP and depth untouched.
  always_comb begin
    sp_d     = sp_q;
    depth_d  = depth_q;
    result_d = 10'h000;
    case (op_q)
      OP_PUSH: begin
        if (!op_err_q) begin
          sp_d    = sp_q - 8'h01;
          depth_d = depth_q + 9'd1;
        end else begin
          sp_d    = sp_q;
          depth_d = depth_q;
        end
      end
      OP_POP: begin
        if (!op_err_q) begin
          sp_d     = sp_q + 8'h01;
          depth_d  = depth_q - 9'd1;
          result_d = scr_data_in_i;
        end else begin
          sp_d     = sp_q;
          depth_d  = depth_q;
          result_d = 10'h000;
        end
      end
      OP_LD: begin
        result_d = scr_data_in_i;
      end
      OP_WSP: begin
        sp_d    = op_addr_q;
        depth_d = 9'd0;
      end
      OP_RSP: begin
        result_d = {2'b00, sp_q};
      end
      default: begin
        result_d = 10'h000;
      end
    endcase
  end

  // Sequencer with all outputs registered; reset aborts any op in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      op_q           <= OP_PUSH;
      op_addr_q      <= 8'h00;
      op_err_q       <= 1'b0;
      sp_q           <= SP_RESET;
      depth_q        <= 9'd0;
      result_q       <= 10'h000;
      err_q          <= 1'b0;
      result_valid_q <= 1'b0;
      op_ready_q     <= 1'b1;
      scr_addr_q     <= 8'h00;
      scr_we_q       <= 1'b0;
      scr_data_q     <= 10'h000;
    end else begin
      case (state_q)
        ST_IDLE: begin
          result_valid_q <= 1'b0;
          if (accept_s) begin
            op_q       <= op_if.op_code;
            op_addr_q  <= op_if.op_addr;
            op_err_q   <= op_err_d;
            scr_addr_q <= scr_addr_d;
            scr_we_q   <= scr_we_d;
            scr_data_q <= scr_data_d;
            op_ready_q <= 1'b0;
            state_q    <= ST_EXEC;
          end else begin
            op_ready_q <= 1'b1;
            state_q    <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          sp_q           <= sp_d;
          depth_q        <= depth_d;
          result_q       <= result_d;
          err_q          <= op_err_q;
          result_valid_q <= 1'b1;
          scr_addr_q     <= 8'h00;
          scr_we_q       <= 1'b0;
          scr_data_q     <= 10'h000;
          state_q        <= ST_DONE;
        end
        ST_DONE: begin
          result_valid_q <= 1'b0;
          op_ready_q     <= 1'b1;
          state_q        <= ST_IDLE;
        end
        default: begin
          result_valid_q <= 1'b0;
          scr_we_q       <= 1'b0;
          scr_addr_q     <= 8'h00;
          scr_data_q     <= 10'h000;
          op_ready_q     <= 1'b1;
          state_q        <= ST_IDLE;
        end
      endcase
    end
  end

  assign op_if.op_ready     = op_ready_q;
  assign op_if.result_valid = result_valid_q;
  assign op_if.result       = result_q;
  assign op_if.err          = err_q;
  assign sp_o               = sp_q;
  assign scr_addr_o         = scr_addr_q;
  assign scr_we_o           = scr_we_q;
  assign scr_data_out_o     = scr_data_q;

endmodule

// File: tb/tb_scr_stack_ctrl.sv
// Directed bench for scr_stack_ctrl with a behavioural 256x10 scratch RAM.
module tb_scr_stack_ctrl;
  import scr_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sp;
  logic [7:0] scr_addr;
  logic       scr_we;
  logic [9:0] scr_dout;
  logic [9:0] scr_din;

  logic [9:0] mem [256];
  int         wr_cnt = 0;
  logic [7:0] last_waddr = 8'h00;
  logic [9:0] last_wdata = 10'h000;

  int n_checks = 0;
  int n_fail   = 0;

  scr_stack_ctrl_if u_if ();

  scr_stack_ctrl #(.SP_RESET(8'h00)) dut (
    .clk            (clk),
    .rst            (rst),
    .op_if          (u_if.slave),
    .sp_o           (sp),
    .scr_addr_o     (scr_addr),
    .scr_we_o       (scr_we),
    .scr_data_out_o (scr_dout),
    .scr_data_in_i  (scr_din)
  );

  always #5 clk = ~clk;

  // Scratch RAM: combinational read, synchronous write
  assign scr_din = mem[scr_addr];
  always @(posedge clk) begin
    if (scr_we) begin
      mem[scr_addr] <= scr_dout;
      wr_cnt        <= wr_cnt + 1;
      last_waddr    <= scr_addr;
      last_wdata    <= scr_dout;
    end
  end

  typedef struct {
    scr_op_t    op;
    logic [7:0] addr;
    logic [9:0] data;
    logic [9:0] exp_res;
    logic       exp_err;
    logic [7:0] exp_sp;
    int         exp_wr;
    logic [7:0] exp_waddr;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  function automatic vec_t mk(input scr_op_t op, input logic [7:0] addr,
                              input logic [9:0] data, input logic [9:0] res,
                              input logic e, input logic [7:0] s,
                              input int wr, input logic [7:0] wa);
    vec_t v;
    v.op = op; v.addr = addr; v.data = data; v.exp_res = res;
    v.exp_err = e; v.exp_sp = s; v.exp_wr = wr; v.exp_waddr = wa;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one request and wait for its completion pulse.
  task automatic do_op(input scr_op_t op, input logic [7:0] addr, input logic [9:0] data,
                       output logic [9:0] res, output logic e, output logic [7:0] s,
                       output int wr, output int lat);
    int guard;
    int wr0;
    guard = 0;
    while (!u_if.op_ready && guard < 10) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 10) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: op_ready never rose");
    end
    u_if.op_valid = 1'b1;
    u_if.op_code  = op;
    u_if.op_addr  = addr;
    u_if.op_data  = data;
    wr0 = wr_cnt;
    @(posedge clk); #1;
    u_if.op_valid = 1'b0;
    lat = 1;
    while (!u_if.result_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    res = u_if.result;
    e   = u_if.err;
    s   = sp;
    wr  = wr_cnt - wr0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] res;
    logic       e;
    logic [7:0] s;
    int         wr;
    int         lat;
    int         bad;
    int         wr0;
    int         rv_seen;

    vecs[0]  = mk(OP_PUSH, 8'h00, 10'h155, 10'h000, 1'b0, 8'hFF, 1, 8'hFF);
    vecs[1]  = mk(OP_PUSH, 8'h00, 10'h2AA, 10'h000, 1'b0, 8'hFE, 1, 8'hFE);
    vecs[2]  = mk(OP_POP,  8'h00, 10'h000, 10'h2AA, 1'b0, 8'hFF, 0, 8'h00);
    vecs[3]  = mk(OP_POP,  8'h00, 10'h000, 10'h155, 1'b0, 8'h00, 0, 8'h00);
    vecs[4]  = mk(OP_POP,  8'h00, 10'h000, 10'h000, 1'b1, 8'h00, 0, 8'h00);
    vecs[5]  = mk(OP_ST,   8'h40, 10'h0AB, 10'h000, 1'b0, 8'h00, 1, 8'h40);
    vecs[6]  = mk(OP_LD,   8'h40, 10'h000, 10'h0AB, 1'b0, 8'h00, 0, 8'h00);
    vecs[7]  = mk(OP_WSP,  8'h80, 10'h000, 10'h000, 1'b0, 8'h80, 0, 8'h00);
    vecs[8]  = mk(OP_RSP,  8'h00, 10'h000, 10'h080, 1'b0, 8'h80, 0, 8'h00);
    vecs[9]  = mk(scr_op_t'(3'd6), 8'h12, 10'h3FF, 10'h000, 1'b0, 8'h80, 0, 8'h00);
    vecs[10] = mk(OP_POP,  8'h00, 10'h000, 10'h000, 1'b1, 8'h80, 0, 8'h00);
    vecs[11] = mk(OP_PUSH, 8'h00, 10'h003, 10'h000, 1'b0, 8'h7F, 1, 8'h7F);
    vecs[12] = mk(OP_RSP,  8'h00, 10'h000, 10'h07F, 1'b0, 8'h7F, 0, 8'h00);
    vecs[13] = mk(scr_op_t'(3'd7), 8'h11, 10'h3FF, 10'h000, 1'b0, 8'h7F, 0, 8'h00);
    vecs[14] = mk(OP_POP,  8'h00, 10'h000, 10'h003, 1'b0, 8'h80, 0, 8'h00);

    u_if.op_valid = 1'b0;
    u_if.op_code  = OP_PUSH;
    u_if.op_addr  = 8'h00;
    u_if.op_data  = 10'h000;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sp",       {24'd0, sp}, 32'h00);
    chk("rst_rv",       {31'd0, u_if.result_valid}, 32'd0);
    chk("rst_result",   {22'd0, u_if.result}, 32'h000);
    chk("rst_err",      {31'd0, u_if.err}, 32'd0);
    chk("rst_we",       {31'd0, scr_we}, 32'd0);
    chk("rst_addr",     {24'd0, scr_addr}, 32'h00);
    chk("rst_dout",     {22'd0, scr_dout}, 32'h000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready",    {31'd0, u_if.op_ready}, 32'd1);

    // Table-driven operations
    for (int i = 0; i < NV; i++) begin
      do_op(vecs[i].op, vecs[i].addr, vecs[i].data, res, e, s, wr, lat);
      chk($sformatf("v%0d_result", i), {22'd0, res}, {22'd0, vecs[i].exp_res});
      chk($sformatf("v%0d_err", i),    {31'd0, e},   {31'd0, vecs[i].exp_err});
      chk($sformatf("v%0d_sp", i),     {24'd0, s},   {24'd0, vecs[i].exp_sp});
      chk($sformatf("v%0d_writes", i), wr, vecs[i].exp_wr);
      chk($sformatf("v%0d_latency", i), lat, 2);
      if (vecs[i].exp_wr == 1) begin
        chk($sformatf("v%0d_waddr", i), {24'd0, last_waddr}, {24'd0, vecs[i].exp_waddr});
        chk($sformatf("v%0d_wdata", i), {22'd0, last_wdata}, {22'd0, vecs[i].data});
      end
    end

    // Result and error hold while idle
    repeat (4) @(posedge clk);
    #1;
    chk("hold_result", {22'd0, u_if.result}, 32'h003);
    chk("hold_rv",     {31'd0, u_if.result_valid}, 32'd0);
    chk("hold_ready",  {31'd0, u_if.op_ready}, 32'd1);

    // Overflow: 256 pushes fill the stack, the 257th faults
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      do_op(OP_PUSH, 8'h00, 10'(i), res, e, s, wr, lat);
      if (e !== 1'b0 || wr != 1 || s !== 8'(255 - i)) bad++;
    end
    chk("fill_bad_pushes", bad, 0);
    chk("fill_sp", {24'd0, sp}, 32'h00);
    do_op(OP_PUSH, 8'h00, 10'h3FF, res, e, s, wr, lat);
    chk("ovf_err",    {31'd0, e}, 32'd1);
    chk("ovf_writes", wr, 0);
    chk("ovf_sp",     {24'd0, s}, 32'h00);
    do_op(OP_POP, 8'h00, 10'h000, res, e, s, wr, lat);
    chk("ovf_pop_result", {22'd0, res}, 32'h0FF);
    chk("ovf_pop_err",    {31'd0, e}, 32'd0);
    chk("ovf_pop_sp",     {24'd0, s}, 32'h01);

    // Reset asserted while a PUSH is in EXEC
    do_op(OP_WSP, 8'h40, 10'h000, res, e, s, wr, lat);
    chk("abort_pre_sp", {24'd0, s}, 32'h40);
    while (!u_if.op_ready) begin
      @(posedge clk); #1;
    end
    u_if.op_valid = 1'b1;
    u_if.op_code  = OP_PUSH;
    u_if.op_data  = 10'h1C3;
    wr0 = wr_cnt;
    @(posedge clk); #1;
    u_if.op_valid = 1'b0;
    chk("abort_exec_we",   {31'd0, scr_we}, 32'd1);
    chk("abort_exec_addr", {24'd0, scr_addr}, 32'h3F);
    rst = 1'b1;
    #1;
    chk("abort_we_drop",   {31'd0, scr_we}, 32'd0);
    chk("abort_addr_zero", {24'd0, scr_addr}, 32'h00);
    chk("abort_sp_reset",  {24'd0, sp}, 32'h00);
    @(negedge clk);
    rst = 1'b0;
    rv_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (u_if.result_valid) rv_seen++;
    end
    chk("abort_no_rv",    rv_seen, 0);
    chk("abort_no_write", wr_cnt - wr0, 0);
    chk("abort_sp_after", {24'd0, sp}, 32'h00);
    chk("abort_ready",    {31'd0, u_if.op_ready}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
